// File: rtl/bm_sqrt_interp.sv
// bm_sqrt_interp: piecewise-linear sqrt of unsigned Q8.24 x into Q4.16 for the Box-Muller path.
// Normalises x to m*4^k, addresses the coefficient ROM, interpolates base+slope*frac,
// then rescales by 2^k. Three registered stages plus the output register, valid/ready flow.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      input handshake, in_data = x (Q8.24)
//   rom_addr/rom_rdata     ROM address out, {base Q1.19, slope} back one cycle later
//   out_valid/out_ready    output handshake, out_data = sqrt(x) (Q4.16)
// Optional: define BM_SQRT_RND_EN for round-half-up interpolation and final shift
// (saturating); otherwise both truncate.
module bm_sqrt_interp #(
    parameter int DIN_F  = 24,
    parameter int FRAC_W = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [6:0]  rom_addr,
    input  logic [32:0] rom_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data
);
    localparam int NBW = 6 + FRAC_W;

    logic               en;
    logic [31:0]        x1;
    logic               v1, v2, v3;
    logic [5:0]         lz;
    logic signed [6:0]  e;
    logic [NBW-1:0]     nb;
    logic               z1, z2, z3;
    logic [6:0]         addr1, addr2;
    logic [FRAC_W-1:0]  frac1, frac2;
    logic signed [3:0]  k1, k2, k3;
    logic [12+FRAC_W:0] prod3;
    logic [19:0]        base3;
    logic [3:0]         rs;
    logic [19:0]        res;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    // During a stall the ROM keeps re-reading the S2 address so its data stays valid for S2.
    assign rom_addr = en ? addr1 : addr2;

    always_comb begin
        lz = 6'd32;
        for (int i = 0; i < 32; i++)
            if (x1[i]) lz = 6'(31 - i);
    end

    // nb holds the mantissa bits just below the leading one: 6 address bits then the fraction.
    assign nb    = NBW'((x1 << lz) >> (25 - FRAC_W));
    assign e     = 7'(31 - DIN_F) - 7'(lz);
    assign k1    = 4'(e >>> 1);
    assign z1    = x1 == 32'd0;
    assign addr1 = z1 ? 7'd0 : {e[0], nb[NBW-1 -: 6]};
    assign frac1 = nb[FRAC_W-1:0];
    assign rs    = 4'd3 - k3;

`ifdef BM_SQRT_RND_EN
    logic [21:0] ysum, ysh;
    always_comb begin
        ysum = 22'(base3)
             + 22'((27'(prod3) + 27'(1 << (FRAC_W - 1))) >> FRAC_W)
             + (rs != 4'd0 ? 22'd1 << (rs - 4'd1) : 22'd0);
        ysh  = ysum >> rs;
        res  = |ysh[21:20] ? 20'hFFFFF : ysh[19:0];
    end
`else
    assign res = 20'(base3 + 20'(prod3 >> FRAC_W)) >> rs;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            x1        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            x1        <= in_data;
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            out_data  <= z3 ? 20'd0 : res;
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            addr2 <= addr1;
            frac2 <= frac1;
            k2    <= k1;
            z2    <= z1;
            prod3 <= rom_rdata[12:0] * frac2;
            base3 <= rom_rdata[32:13];
            k3    <= k2;
            z3    <= z2;
        end
    end
endmodule

// File: tb/tb_bm_sqrt_interp.sv
// tb_bm_sqrt_interp: scoreboard bench for bm_sqrt_interp with a registered coefficient ROM model.
module tb_bm_sqrt_interp;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [6:0]  rom_addr;
    logic [32:0] rom_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;

    logic [32:0] rom [128];
    int          queue_exp[$];
    int          checks = 0;
    int          failures = 0;
    logic [19:0] last_out;

    bm_sqrt_interp dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clock = ~clock;

    // Table: base = round(sqrt(m)*2^19)+3, slope spans to the next entry, clamped below 2^20.
    initial begin
        for (int a = 0; a < 128; a++) begin
            real m, mn;
            int  b, bn, s;
            m  = (1.0 + (a % 64) / 64.0) * ((a >= 64) ? 2.0 : 1.0);
            mn = (1.0 + (a % 64 + 1) / 64.0) * ((a >= 64) ? 2.0 : 1.0);
            b  = $rtoi($sqrt(m) * 524288.0 + 0.5) + 3;
            bn = $rtoi($sqrt(mn) * 524288.0 + 0.5) + 3;
            s  = bn - b;
            if (b + s > 1048575) s = 1048575 - b;
            rom[a] = {20'(b), 13'(s)};
        end
    end

    always @(posedge clock) rom_rdata <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [31:0] x);
        int          p, k, rs, y, base, slope;
        logic [31:0] xn;
        logic [6:0]  idx;
        logic [11:0] frac;
        if (x == 0) return 0;
        p = 31;
        while (!x[p]) p--;
        k     = (p - 24 + 24) / 2 - 12;
        xn    = x << (31 - p);
        idx   = {p[0], xn[30:25]};
        frac  = xn[24:13];
        base  = int'(rom[idx][32:13]);
        slope = int'(rom[idx][12:0]);
        rs    = 3 - k;
`ifdef BM_SQRT_RND_EN
        y = base + ((slope * int'(frac) + 2048) >> 12);
        y = (y + (rs > 0 ? 1 << (rs - 1) : 0)) >> rs;
        if (y > 1048575) y = 1048575;
`else
        y = (base + ((slope * int'(frac)) >> 12)) >> rs;
`endif
        return y;
    endfunction

    always @(negedge clock) begin
        if (reset) queue_exp.delete();
        else begin
            if (out_valid && out_ready) begin
                if (queue_exp.size() == 0) chk("sb_extra", 32'(out_valid), 0);
                else chk("sb_data", 32'(out_data), queue_exp.pop_front());
            end
            if (in_valid && in_ready) queue_exp.push_back(model(in_data));
        end
    end

    task automatic single(input logic [31:0] x, input logic [6:0] a, input int o, input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_addr"}, 32'(rom_addr), 32'(a));
        chk({tag, "_lat1"}, 32'(out_valid), 0);
        @(negedge clock);
        chk({tag, "_lat2"}, 32'(out_valid), 0);
        @(negedge clock);
        chk({tag, "_lat3"}, 32'(out_valid), 0);
        @(negedge clock);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        last_out = out_data;
`ifndef BM_SQRT_RND_EN
        if (o >= 0) chk({tag, "_data"}, 32'(out_data), 32'(o));
`endif
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int exp4[4] = '{65536, 92682, 131072, 80265};
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        @(posedge clock); #1;

        single(32'h0100_0000, 7'd0,   65536,  "one");
        single(32'h0200_0000, 7'd64,  92682,  "two");
        single(32'h0400_0000, 7'd0,   131072, "four");
        single(32'h0180_0000, 7'd32,  80265,  "onehalf");
        single(32'h0000_0000, 7'd0,   0,      "zero");
        single(32'hFFFF_FFFF, 7'd127, -1,     "max");
        chk("max_near16", 32'(last_out > 20'hFF000), 1);

        in_valid = 1'b1; in_data = 32'h0100_0000;
        @(posedge clock); #1 in_data = 32'h0200_0000;
        @(posedge clock); #1 in_data = 32'h0400_0000;
        @(posedge clock); #1 in_data = 32'h0180_0000;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 65536);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_rom_addr", 32'(rom_addr), 0);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            chk("order_valid", 32'(out_valid), 1);
`ifndef BM_SQRT_RND_EN
            chk("order_data", 32'(out_data), 32'(exp4[j]));
`endif
            @(posedge clock); #1;
        end

        in_valid = 1'b1; in_data = 32'h0100_0000;
        @(posedge clock); #1 in_data = 32'h0200_0000;
        @(posedge clock); #1 in_data = 32'h0400_0000;
        @(posedge clock); #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("mid_rst_valid", 32'(out_valid), 0);
        end
        @(posedge clock); #1;
        single(32'h0100_0000, 7'd0, 65536, "post_rst");

        for (int c = 0; c < 400; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && queue_exp.size() != 0; c++) @(posedge clock);
        #1 chk("drain_empty", 32'(queue_exp.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
